// File: rtl/debug_dump_pkg.sv
// Shared definitions for the debug unit: frame markers, dump sections and
// transmit FSM states.
package debug_dump_pkg;

  localparam logic [7:0] DBG_HDR = 8'hA5;
  localparam logic [7:0] DBG_TRL = 8'h5A;

  typedef enum logic [1:0] {SEC_PC, SEC_LATCH, SEC_REG, SEC_MEM} section_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_SEL, ST_WAIT, ST_LOAD, ST_BYTE, ST_TRL, ST_DONE
  } state_t;

  // Counter width able to hold 0..maxVal-1, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal) : 1;
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debug_dump_tx_uart.sv
// UART 8N1 byte transmitter. A new byte may be accepted in the last stop-bit
// cycle (tx_done) so back-to-back bytes leave no idle gap.
module uart_tx_byte
  import debug_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_go,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int BAUD_W = cntWidth(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baudCnt;
  logic [3:0]        bitCnt;
  logic [8:0]        shiftReg;
  logic              busyReg;
  logic              txReg;
  logic              bitEnd;

  assign bitEnd  = (baudCnt == BAUD_LAST);
  assign tx_done = busyReg && bitEnd && (bitCnt == 4'd9);
  assign tx_busy = busyReg;
  assign tx      = txReg;

  // bitCnt: 0 = start bit, 1..8 = data LSB first, 9 = stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '1;
      busyReg  <= 1'b0;
      txReg    <= 1'b1;
    end else if (tx_go && (!busyReg || tx_done)) begin
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= {1'b1, tx_data};
      busyReg  <= 1'b1;
      txReg    <= 1'b0;
    end else if (busyReg) begin
      if (bitEnd) begin
        baudCnt <= '0;
        if (bitCnt == 4'd9) begin
          busyReg <= 1'b0;
        end else begin
          bitCnt   <= bitCnt + 4'd1;
          txReg    <= shiftReg[0];
          shiftReg <= {1'b1, shiftReg[8:1]};
        end
      end else begin
        baudCnt <= baudCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on start, sends header, PC, latch words, register
// file, data memory and trailer as a stream of UART bytes.
module debug_dump_tx
  import debug_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int N_LATCH      = 32,
  parameter int N_REGS       = 32,
  parameter int N_MEM        = 32,
  parameter int SETTLE       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_latch,
  input  logic [31:0] in_fr_data,
  input  logic [31:0] in_mem_data,
  output logic [6:0]  latch_sel,
  output logic [31:0] debug_addr,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int IDX_W = cntWidth(maxOf3(N_LATCH, N_REGS, N_MEM));
  localparam int SET_W = cntWidth(SETTLE);

  state_t            state;
  section_t          section;
  logic [IDX_W-1:0]  wordIdx;
  logic [1:0]        byteCnt;
  logic [SET_W-1:0]  settleCnt;
  logic [31:0]       shiftReg;
  logic [31:0]       srcWord;
  logic              goReg, busyReg, doneReg;
  logic [6:0]        latchSelReg;
  logic [31:0]       debugAddrReg;
  logic              secLast, lastWord;
  logic              txGo, txBusy, txDone;
  logic [7:0]        txData;

  always_comb begin
    srcWord = in_pc;
    secLast = 1'b1;
    case (section)
      SEC_LATCH: begin
        srcWord = in_latch;
        secLast = (wordIdx == IDX_W'(N_LATCH - 1));
      end
      SEC_REG: begin
        srcWord = in_fr_data;
        secLast = (wordIdx == IDX_W'(N_REGS - 1));
      end
      SEC_MEM: begin
        srcWord = in_mem_data;
        secLast = (wordIdx == IDX_W'(N_MEM - 1));
      end
      default: ;
    endcase
    lastWord = (section == SEC_MEM) && secLast;
  end

  // Bytes within a word and the trailer are chained off tx_done so the next
  // start bit directly follows the previous stop bit.
  always_comb begin
    txGo   = goReg;
    txData = (state == ST_HDR) ? DBG_HDR : shiftReg[31:24];
    if (state == ST_BYTE && txDone) begin
      if (byteCnt != 2'd3) begin
        txGo   = 1'b1;
        txData = shiftReg[23:16];
      end else if (lastWord) begin
        txGo   = 1'b1;
        txData = DBG_TRL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      section      <= SEC_PC;
      wordIdx      <= '0;
      byteCnt      <= '0;
      settleCnt    <= '0;
      shiftReg     <= '0;
      goReg        <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      latchSelReg  <= '0;
      debugAddrReg <= '0;
    end else begin
      goReg <= 1'b0;
      case (state)
        ST_IDLE: if (start && !txBusy) begin
          state   <= ST_HDR;
          busyReg <= 1'b1;
          goReg   <= 1'b1;
        end
        ST_HDR: if (txDone) begin
          section <= SEC_PC;
          wordIdx <= '0;
          state   <= ST_SEL;
        end
        ST_SEL: begin
          case (section)
            SEC_LATCH:        latchSelReg  <= 7'(wordIdx);
            SEC_REG, SEC_MEM: debugAddrReg <= 32'(wordIdx);
            default: ;
          endcase
          settleCnt <= '0;
          state     <= ST_WAIT;
        end
        // Capture on the edge that closes the last settle cycle.
        ST_WAIT: if (settleCnt == SET_W'(SETTLE - 1)) begin
          shiftReg <= srcWord;
          byteCnt  <= '0;
          goReg    <= 1'b1;
          state    <= ST_LOAD;
        end else begin
          settleCnt <= settleCnt + 1'b1;
        end
        ST_LOAD: state <= ST_BYTE;
        ST_BYTE: if (txDone) begin
          if (byteCnt != 2'd3) begin
            byteCnt  <= byteCnt + 2'd1;
            shiftReg <= {shiftReg[23:0], 8'h00};
          end else if (lastWord) begin
            state <= ST_TRL;
          end else begin
            if (secLast) begin
              section <= section_t'(section + 2'd1);
              wordIdx <= '0;
            end else begin
              wordIdx <= wordIdx + 1'b1;
            end
            state <= ST_SEL;
          end
        end
        ST_TRL: if (txDone) begin
          doneReg <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          doneReg      <= 1'b0;
          busyReg      <= 1'b0;
          latchSelReg  <= '0;
          debugAddrReg <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) uartTx (
    .clk     (clk),
    .rst     (rst),
    .tx_go   (txGo),
    .tx_data (txData),
    .tx_busy (txBusy),
    .tx_done (txDone),
    .tx      (tx)
  );

  assign latch_sel  = latchSelReg;
  assign debug_addr = debugAddrReg;
  assign busy       = busyReg;
  assign done       = doneReg;

endmodule
